// File: rtl/vector_mem_loader.sv
// Start-switch debounce plus word loader that fills the processor data memory while holding it in reset.
// Optional build macro LOADER_CHECKSUM_EN adds a running 32-bit sum of loaded words on the checksum port.
module vector_mem_loader #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int NUM_WORDS       = 1024,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  switchStart,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  proc_rst,
    output logic                  proc_start,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           checksum
);
    localparam int CNT_W = $clog2(NUM_WORDS + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN} state_t;
    state_t r_state, w_next;

    logic            r_sync1, r_sync2, r_stable, r_stable_d, r_start_req;
    logic [DB_W-1:0] r_db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_stable    <= 1'b0;
            r_stable_d  <= 1'b0;
            r_db_cnt    <= '0;
            r_start_req <= 1'b0;
        end else begin
            r_sync1     <= switchStart;
            r_sync2     <= r_sync1;
            r_stable_d  <= r_stable;
            r_start_req <= r_stable & ~r_stable_d;
            if (r_sync2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    logic [CNT_W-1:0] r_count;
    logic             w_beat, w_last, w_enter_load;

    assign w_beat       = src_valid && src_ready;
    assign w_last       = (r_count == CNT_W'(NUM_WORDS - 1));
    assign w_enter_load = r_start_req && (r_state == S_IDLE || r_state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        src_ready = 1'b0;
        proc_rst  = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: if (r_start_req) w_next = S_LOAD;
            S_LOAD: begin
                src_ready = 1'b1;
                busy      = 1'b1;
                if (w_beat && w_last) w_next = S_RELEASE;
            end
            S_RELEASE: begin
                proc_rst = 1'b0;
                busy     = 1'b1;
                w_next   = S_RUN;
            end
            S_RUN: begin
                proc_rst = 1'b0;
                done     = 1'b1;
                if (r_start_req) w_next = S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    logic                  r_mem_we, r_proc_start;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    // Write port is registered: a beat at edge N is presented during cycle N..N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_count      <= '0;
            r_proc_start <= 1'b0;
        end else begin
            r_mem_we     <= w_beat;
            r_proc_start <= (r_state == S_RELEASE);
            if (w_enter_load) begin
                r_count    <= '0;
                r_mem_addr <= '0;
            end else if (w_beat) begin
                r_mem_addr  <= ADDR_WIDTH'(r_count);
                r_mem_wdata <= src_data;
                r_count     <= r_count + CNT_W'(1);
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign proc_start = r_proc_start;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst || w_enter_load) r_checksum <= '0;
        else if (w_beat)         r_checksum <= r_checksum + 32'(src_data);
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_vector_mem_loader.sv
// Scoreboard bench for vector_mem_loader: expected writes queued at issue, checked by a write monitor.
module tb_vector_mem_loader;
    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst, switchStart, src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready, mem_we, proc_rst, proc_start, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [31:0]   checksum;

    vector_mem_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(4), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .switchStart(switchStart),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .proc_rst(proc_rst), .proc_start(proc_start), .busy(busy), .done(done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    exp_addr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write monitor: every presented write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (proc_start === 1'b1) n_start++;
        if (mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", mem_addr, mem_wdata);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             mem_addr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d);
        int t;
        t = 0;
        src_valid = 1'b1;
        src_data  = d;
        while (src_ready !== 1'b1 && t < 20) begin
            tick(1);
            t++;
        end
        if (src_ready !== 1'b1) begin
            chk("send_timeout", 32'(src_ready), 32'd1);
        end else begin
            exp_q.push_back({exp_addr, d});
            exp_addr++;
        end
        tick(1);
        src_valid = 1'b0;
    endtask

    task automatic press_wait(input string nm);
        int t;
        t = 0;
        switchStart = 1'b1;
        while (busy !== 1'b1 && t < 40) begin
            tick(1);
            t++;
        end
        chk(nm, 32'(busy), 32'd1);
    endtask

    logic [31:0] cks_exp;

    initial begin
        int pv[7];
        pv = '{1, 0, 0, 1, 1, 0, 1};
        rst = 1'b1; switchStart = 1'b0; src_valid = 1'b0; src_data = '0;
        tick(2);
        chk("rst_proc_rst", 32'(proc_rst), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        rst = 1'b0;
        tick(50);
        chk("idle_proc_rst", 32'(proc_rst), 32'd1);
        chk("idle_src_ready", 32'(src_ready), 32'd0);
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_no_start", 32'(n_start), 32'd0);

        // Three-cycle glitch must be rejected.
        switchStart = 1'b1; tick(3); switchStart = 1'b0;
        tick(20);
        chk("glitch_busy", 32'(busy), 32'd0);

        // Clean press: sync1 captures at E0, LOAD visible from E7.
        switchStart = 1'b1;
        tick(7);
        chk("latency_pre_busy", 32'(busy), 32'd0);
        tick(1);
        chk("latency_busy", 32'(busy), 32'd1);
        chk("latency_src_ready", 32'(src_ready), 32'd1);

        exp_addr = '0;
        send(32'h11); send(32'h22); send(32'h33); send(32'h44);
        src_valid = 1'b1; src_data = 32'h55;   // must not be accepted
        chk("rel_src_ready", 32'(src_ready), 32'd0);
        chk("rel_proc_rst", 32'(proc_rst), 32'd0);
        chk("rel_busy", 32'(busy), 32'd1);
        chk("rel_last_we", 32'(mem_we), 32'd1);
        tick(1);
        src_valid = 1'b0;
        chk("run_proc_start", 32'(proc_start), 32'd1);
        chk("run_done", 32'(done), 32'd1);
        chk("run_mem_we", 32'(mem_we), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        cks_exp = 32'hAA;
`else
        cks_exp = 32'h0;
`endif
        chk("run_checksum", checksum, cks_exp);
        tick(1);
        chk("run_pulse_end", 32'(proc_start), 32'd0);
        chk("start_count1", 32'(n_start), 32'd1);

        // Falling edge ignored, then reload from RUN.
        switchStart = 1'b0; tick(10);
        chk("fall_done", 32'(done), 32'd1);
        press_wait("reload_busy");
        chk("reload_proc_rst", 32'(proc_rst), 32'd1);

        // Press during LOAD is ignored.
        switchStart = 1'b0; tick(8);
        switchStart = 1'b1; tick(9);
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_src_ready", 32'(src_ready), 32'd1);
        chk("ign_mem_we", 32'(mem_we), 32'd0);

        // Back-pressure pattern.
        exp_addr = '0;
        for (int i = 0; i < 7; i++) begin
            src_valid = pv[i][0];
            src_data  = 32'(5 + int'(exp_addr));
            if (pv[i] == 1) begin
                exp_q.push_back({exp_addr, src_data});
                exp_addr++;
            end
            tick(1);
            chk("bp_mem_we", 32'(mem_we), 32'(pv[i]));
        end
        src_valid = 1'b0;
        chk("bp_src_ready", 32'(src_ready), 32'd0);
        tick(1);
        chk("bp_proc_start", 32'(proc_start), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        cks_exp = 32'h1A;
`else
        cks_exp = 32'h0;
`endif
        chk("bp_checksum", checksum, cks_exp);
        tick(1);
        chk("start_count2", 32'(n_start), 32'd2);

        // Reset mid-load, then the still-high switch restarts from addr 0.
        switchStart = 1'b0; tick(10);
        press_wait("mid_busy");
        exp_addr = '0;
        send(32'h1); send(32'h2);
        rst = 1'b1;
        tick(1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_proc_rst", 32'(proc_rst), 32'd1);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        press_wait("after_rst_busy");
        exp_addr = '0;
        send(32'h3); send(32'h4); send(32'h5); send(32'h6);
        tick(1);
        chk("final_done", 32'(done), 32'd1);
`ifdef LOADER_CHECKSUM_EN
        cks_exp = 32'h12;
`else
        cks_exp = 32'h0;
`endif
        chk("final_checksum", checksum, cks_exp);
        tick(2);
        chk("start_count3", 32'(n_start), 32'd3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
